// File: rtl/logic_pkg.sv
// Shared definitions for the two-requester logic/shift unit arbiter:
// opcode encodings and the control FSM state type.
package logic_pkg;

  localparam int W = 4;

  localparam logic [3:0] OP_AND        = 4'd0;
  localparam logic [3:0] OP_OR         = 4'd1;
  localparam logic [3:0] OP_XOR        = 4'd2;
  localparam logic [3:0] OP_ASR        = 4'd3;
  localparam logic [3:0] OP_ASL        = 4'd4;
  localparam logic [3:0] OP_LSR        = 4'd5;
  localparam logic [3:0] OP_LSL        = 4'd6;
  localparam logic [3:0] OP_NOT        = 4'd7;
  localparam logic [3:0] OP_ROR        = 4'd8;
  localparam logic [3:0] OP_ROL        = 4'd9;
  localparam logic [3:0] OP_LAST_LEGAL = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/logic_alu.sv
// Combinational 4-bit logic/shift unit. Shifts use in2 as an unsigned
// amount; rotates use only in2[1:0]. Codes above the last legal one flag err.
module logic_alu
  import logic_pkg::*;
(
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [3:0]   sel,
  output logic [W-1:0] out,
  output logic         err
);

  logic [2*W-1:0] dbl_r;
  logic [2*W-1:0] dbl_l;
  logic           big_shift;

  // Rotating a doubled copy keeps every rotate amount a plain shift.
  assign dbl_r     = {in1, in1} >> in2[1:0];
  assign dbl_l     = {in1, in1} << in2[1:0];
  assign big_shift = (in2 > 4'd3);

  always_comb begin
    out = '0;
    err = 1'b0;
    case (sel)
      OP_AND: out = in1 & in2;
      OP_OR:  out = in1 | in2;
      OP_XOR: out = in1 ^ in2;
      OP_ASR: out = big_shift ? {W{in1[W-1]}} : W'($signed(in1) >>> in2);
      OP_ASL,
      OP_LSL: out = big_shift ? '0 : (in1 << in2);
      OP_LSR: out = big_shift ? '0 : (in1 >> in2);
      OP_NOT: out = ~in1;
      OP_ROR: out = dbl_r[W-1:0];
      OP_ROL: out = dbl_l[2*W-1:W];
      default: begin
        out = '0;
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/logic_arbiter.sv
// Round-robin share of one logic unit between two requesters, with a
// registered execute stage and a single ID-tagged response channel.
module logic_arbiter
  import logic_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [W-1:0] req0_in1,
  input  logic [W-1:0] req0_in2,
  input  logic [3:0]   req0_sel,
  input  logic [W-1:0] req1_in1,
  input  logic [W-1:0] req1_in2,
  input  logic [3:0]   req1_sel,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_id,
  output logic         rsp_err,
  output logic [1:0]   dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // req_ready depends on req_valid combinationally; rsp_valid never
  // depends on rsp_ready and holds until the transfer (or reset).

  state_t       state_q, state_d;
  logic         ptr_q;
  logic [W-1:0] in1_q, in2_q;
  logic [3:0]   sel_q;
  logic         id_q;
  logic [W-1:0] rsp_data_q;
  logic         rsp_id_q, rsp_err_q;

  logic         grant_valid;
  logic         grant_id;
  logic [W-1:0] alu_out;
  logic         alu_err;

  // With both valid the pointer decides; otherwise the lone requester wins.
  assign grant_id    = (req_valid == 2'b11) ? ptr_q : req_valid[1];
  assign grant_valid = (state_q == ST_IDLE) && !rst && (|req_valid);

  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          req_ready = grant_id ? 2'b10 : 2'b01;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 1'b0;
      in1_q      <= '0;
      in2_q      <= '0;
      sel_q      <= '0;
      id_q       <= 1'b0;
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_valid) begin
        in1_q <= grant_id ? req1_in1 : req0_in1;
        in2_q <= grant_id ? req1_in2 : req0_in2;
        sel_q <= grant_id ? req1_sel : req0_sel;
        id_q  <= grant_id;
        ptr_q <= ~grant_id;
      end
      if (state_q == ST_EXEC) begin
        rsp_data_q <= alu_out;
        rsp_err_q  <= alu_err;
        rsp_id_q   <= id_q;
      end
    end
  end

  logic_alu u_alu (
    .in1 (in1_q),
    .in2 (in2_q),
    .sel (sel_q),
    .out (alu_out),
    .err (alu_err)
  );

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

endmodule
